// File: rtl/am2909.sv
`default_nettype none
// ============================================================================
//  Module   : am2909
//  Purpose  : Am2909-style microprogram sequencer slice. Selects the next
//             microinstruction address from the microprogram counter, the
//             auxiliary register, the direct input or the top of a small
//             push/pop stack. It also provides the incrementer carry for
//             cascading slices.
//  Ports    : clk  - clock; all state changes on the rising edge
//             clr  - asynchronous active-high reset
//             d    - direct address input (s = 10)
//             r    - auxiliary register data input
//             orin - OR-mask inputs (only when AM2909_ORIN_EN is defined)
//             s    - address source select (00 upc, 01 ar, 10 d, 11 TOS)
//             fe_  - stack file enable, active low
//             pup  - stack direction, 1 = push, 0 = pop
//             re_  - auxiliary register load enable, active low
//             za_  - zero-force, active low (has priority over the OR-mask)
//             oe_  - output enable, active low (gates the y pins only)
//             cn   - incrementer carry-in
//             y    - next address, high-Z while oe_ = 1
//             cout - incrementer carry-out
//  Config   : `define AM2909_ORIN_EN to add the orin port and OR-mask.
//  Revision : 1.0 - initial release
// ============================================================================
module am2909 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4   // power of two, at least 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] r,
`ifdef AM2909_ORIN_EN
  input  logic [WIDTH-1:0] orin,
`endif
  input  logic [1:0]       s,
  input  logic             fe_,
  input  logic             pup,
  input  logic             re_,
  input  logic             za_,
  input  logic             oe_,
  input  logic             cn,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  localparam int c_SP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  r_upc;
  logic [WIDTH-1:0]  r_ar;
  logic [c_SP_W-1:0] r_sp;
  logic [WIDTH-1:0]  r_stk [DEPTH];

  logic [WIDTH-1:0]  w_m;
  logic [WIDTH-1:0]  w_yi;
  logic [WIDTH-1:0]  w_inc;
  logic [c_SP_W-1:0] w_sp_inc;
  logic [c_SP_W-1:0] w_sp_dec;

  // Address source mux
  always_comb begin
    w_m = r_upc;
    unique case (s)
      2'b00:   w_m = r_upc;
      2'b01:   w_m = r_ar;
      2'b10:   w_m = d;
      default: w_m = r_stk[r_sp];
    endcase
  end

  // Zero-force wins over the OR-mask
`ifdef AM2909_ORIN_EN
  assign w_yi = za_ ? (w_m | orin) : '0;
`else
  assign w_yi = za_ ? w_m : '0;
`endif

  // Incrementer works on the internal address, so it runs even with y tristated
  assign {cout, w_inc} = {1'b0, w_yi} + {{WIDTH{1'b0}}, cn};

  assign y = oe_ ? {WIDTH{1'bz}} : w_yi;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two
  assign w_sp_inc = r_sp + 1'b1;
  assign w_sp_dec = r_sp - 1'b1;

  // Microprogram counter and auxiliary register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_upc <= '0;
      r_ar  <= '0;
    end else begin
      r_upc <= w_inc;
      if (!re_) begin
        r_ar <= r;
      end
    end
  end

  // Stack: push stores the pre-edge upc at sp+1, pop only moves the pointer
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_sp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_stk[i] <= '0;
      end
    end else if (!fe_) begin
      if (pup) begin
        r_sp            <= w_sp_inc;
        r_stk[w_sp_inc] <= r_upc;
      end else begin
        r_sp <= w_sp_dec;
      end
    end
  end

endmodule
`default_nettype wire
